// File: rtl/regs_pkg.sv
// regs_pkg: shared defaults and types for the multi-port GPR file.
// Optional same-cycle bypass is enabled by YSYX_23060251_REGS_BYPASS_EN.
package regs_pkg;

  localparam int unsigned REGS_XLEN    = 64;
  localparam int unsigned REGS_NR_REGS = 32;
  localparam int unsigned REGS_AW      = $clog2(REGS_NR_REGS);

  typedef logic [REGS_AW-1:0]   reg_addr_t;
  typedef logic [REGS_XLEN-1:0] xlen_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regs_scoreboard.sv
// regs_scoreboard: per-register pending-write bits.
// Flush clears everything; a same-cycle issue always wins over a clear.
module regs_scoreboard #(
  parameter int unsigned NR_REGS = 32,
  parameter int unsigned AW      = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_i,
  input  logic [AW-1:0]      issue_rd_i,
  input  logic               flush_i,
  input  logic [NR_REGS-1:0] clr_i,
  output logic [NR_REGS-1:0] busy_o
);

  logic [NR_REGS-1:0] busy_q;
  logic [NR_REGS-1:0] busy_d;

  always_comb begin
    busy_d = flush_i ? '0 : (busy_q & ~clr_i);
    if (issue_i) begin
      busy_d[issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regs_mp.sv
// regs_mp: multi-port integer register file with busy scoreboard.
// Define YSYX_23060251_REGS_BYPASS_EN for same-cycle write-to-read bypass.
module regs_mp
  import regs_pkg::*;
#(
  parameter  int unsigned XLEN      = REGS_XLEN,
  parameter  int unsigned NR_REGS   = REGS_NR_REGS,
  parameter  int unsigned NR_RPORTS = 2,
  parameter  int unsigned NR_WPORTS = 2,
  localparam int unsigned AW        = $clog2(NR_REGS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NR_WPORTS-1:0]      wen_i,
  input  logic [NR_WPORTS*AW-1:0]   waddr_i,
  input  logic [NR_WPORTS*XLEN-1:0] wdata_i,
  input  logic                      issue_i,
  input  logic [AW-1:0]             issue_rd_i,
  input  logic                      flush_i,
  input  logic [NR_RPORTS*AW-1:0]   raddr_i,
  output logic [NR_RPORTS*XLEN-1:0] rdata_o,
  output logic [NR_RPORTS-1:0]      busy_o
);

  logic [XLEN-1:0]    gpr_q [NR_REGS];
  logic [XLEN-1:0]    wd    [NR_REGS];
  logic [NR_REGS-1:0] we;
  logic [NR_REGS-1:0] busy;

  // Ascending port scan: the last (highest-index) match wins.
  always_comb begin
    for (int r = 0; r < NR_REGS; r++) begin
      we[r] = 1'b0;
      wd[r] = '0;
      for (int k = 0; k < NR_WPORTS; k++) begin
        if (wen_i[k] && waddr_i[k*AW +: AW] == AW'(r)) begin
          we[r] = 1'b1;
          wd[r] = wdata_i[k*XLEN +: XLEN];
        end
      end
    end
    we[AW'(REG_ZERO)] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NR_REGS; r++) begin
        gpr_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NR_REGS; r++) begin
        if (we[r]) begin
          gpr_q[r] <= wd[r];
        end
      end
    end
  end

  regs_scoreboard #(
    .NR_REGS (NR_REGS),
    .AW      (AW)
  ) u_sb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .issue_i    (issue_i),
    .issue_rd_i (issue_rd_i),
    .flush_i    (flush_i),
    .clr_i      (we),
    .busy_o     (busy)
  );

  always_comb begin
    rdata_o = '0;
    busy_o  = '0;
    for (int p = 0; p < NR_RPORTS; p++) begin
      rdata_o[p*XLEN +: XLEN] = gpr_q[raddr_i[p*AW +: AW]];
      busy_o[p]               = busy[raddr_i[p*AW +: AW]];
`ifdef YSYX_23060251_REGS_BYPASS_EN
      for (int k = 0; k < NR_WPORTS; k++) begin
        if (wen_i[k] &&
            waddr_i[k*AW +: AW] == raddr_i[p*AW +: AW] &&
            raddr_i[p*AW +: AW] != AW'(REG_ZERO)) begin
          rdata_o[p*XLEN +: XLEN] = wdata_i[k*XLEN +: XLEN];
          busy_o[p] = issue_i &&
                      (issue_rd_i == raddr_i[p*AW +: AW]);
        end
      end
`endif
    end
  end

endmodule
